axi_mem_outstanding_limiter: RTL and testbench

- Sits on the core memory path between pardcore M_AXI_MEM and addr_mapper s_axi, in the uncore clock domain.
- Caps outstanding AXI4 read and write bursts at runtime-programmable limits.
- Stops W data from running ahead of its AW.
- Exposes outstanding counts, stall statistics and a sticky protocol-error flag to the control plane.
- Payload passes through with zero added latency; only valid/ready are gated.

---
 rtl/axi_limiter_pkg.sv | 26 ++
 rtl/axi_mem_outstanding_limiter_if.sv | 64 ++++++
 rtl/outstanding_ctr.sv | 35 +++
 rtl/axi_mem_outstanding_limiter.sv | 111 +++++++++++
 tb/tb_axi_mem_outstanding_limiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_limiter_pkg.sv
// Shared types and helpers for the memory-path outstanding limiter.
// Holds default widths and the counter-event classification used by every counter.
package axi_limiter_pkg;

    localparam int CNT_W_DEF  = 5;
    localparam int STAT_W_DEF = 32;

    typedef enum logic [1:0] {
        CTR_HOLD,
        CTR_INC,
        CTR_DEC,
        CTR_UNDERFLOW
    } ctr_act_t;

    function automatic logic hs(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    // Simultaneous increment and decrement cancel; a lone decrement at zero is an underflow.
    function automatic ctr_act_t ctr_action(input logic inc, input logic dec, input logic is_zero);
        if (inc == dec) return CTR_HOLD;
        if (inc) return CTR_INC;
        return is_zero ? CTR_UNDERFLOW : CTR_DEC;
    endfunction

endpackage

// File: rtl/axi_mem_outstanding_limiter_if.sv
// AXI4 memory bus bundle between pardcore and addr_mapper.
// Every channel transfers on a cycle where valid and ready are both high; valid never waits on ready.
interface axi_mem_outstanding_limiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 1,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [USER_W-1:0]   awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [USER_W-1:0]   aruser;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/outstanding_ctr.sv
// Up/down outstanding counter with cancel-on-collision, underflow detect and limit compare.
// Without a limit, ok reports a nonzero count (used as a credit-available flag).
module outstanding_ctr
    import axi_limiter_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit HAS_LIMIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             ok,
    output logic             underflow
);
    ctr_act_t act;

    assign act       = ctr_action(inc, dec, count == '0);
    assign underflow = (act == CTR_UNDERFLOW);
    assign ok        = HAS_LIMIT ? (count < limit) : (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case (act)
                CTR_INC: count <= count + CNT_W'(1);
                CTR_DEC: count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axi_mem_outstanding_limiter.sv
// Caps outstanding AXI4 read/write bursts and holds W behind its AW on the core memory path.
// Payload is pure pass-through; only request-side valid/ready are gated.
module axi_mem_outstanding_limiter
    import axi_limiter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic                uncoreclk,
    input  logic                uncore_rstn,
    axi_mem_outstanding_limiter_if.slave  s_axi,
    axi_mem_outstanding_limiter_if.master m_axi,
    input  logic [CNT_W-1:0]    cfg_max_rd,
    input  logic [CNT_W-1:0]    cfg_max_wr,
    output logic [CNT_W-1:0]    stat_rd_outstanding,
    output logic [CNT_W-1:0]    stat_wr_outstanding,
    output logic [STAT_W-1:0]   stat_rd_stall,
    output logic [STAT_W-1:0]   stat_wr_stall,
    input  logic                stat_clear,
    output logic                err_sticky
);
    logic rd_ok, wr_ok, w_ok;
    logic ar_hs, r_last_hs, aw_hs, b_hs, w_last_hs;
    logic rd_uf, wr_uf, wc_uf;
    logic [CNT_W-1:0] w_cred_unused;

    assign m_axi.awid    = s_axi.awid;
    assign m_axi.awaddr  = s_axi.awaddr;
    assign m_axi.awlen   = s_axi.awlen;
    assign m_axi.awsize  = s_axi.awsize;
    assign m_axi.awburst = s_axi.awburst;
    assign m_axi.awlock  = s_axi.awlock;
    assign m_axi.awcache = s_axi.awcache;
    assign m_axi.awprot  = s_axi.awprot;
    assign m_axi.awqos   = s_axi.awqos;
    assign m_axi.awuser  = s_axi.awuser;
    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = s_axi.wlast;
    assign m_axi.arid    = s_axi.arid;
    assign m_axi.araddr  = s_axi.araddr;
    assign m_axi.arlen   = s_axi.arlen;
    assign m_axi.arsize  = s_axi.arsize;
    assign m_axi.arburst = s_axi.arburst;
    assign m_axi.arlock  = s_axi.arlock;
    assign m_axi.arcache = s_axi.arcache;
    assign m_axi.arprot  = s_axi.arprot;
    assign m_axi.arqos   = s_axi.arqos;
    assign m_axi.aruser  = s_axi.aruser;
    assign s_axi.bid     = m_axi.bid;
    assign s_axi.bresp   = m_axi.bresp;
    assign s_axi.rid     = m_axi.rid;
    assign s_axi.rdata   = m_axi.rdata;
    assign s_axi.rresp   = m_axi.rresp;
    assign s_axi.rlast   = m_axi.rlast;

    // Responses are never gated: throttling them could deadlock the drain.
    assign s_axi.bvalid  = m_axi.bvalid;
    assign m_axi.bready  = s_axi.bready;
    assign s_axi.rvalid  = m_axi.rvalid;
    assign m_axi.rready  = s_axi.rready;

    assign m_axi.arvalid = s_axi.arvalid & rd_ok;
    assign s_axi.arready = m_axi.arready & rd_ok;
    assign m_axi.awvalid = s_axi.awvalid & wr_ok;
    assign s_axi.awready = m_axi.awready & wr_ok;
    assign m_axi.wvalid  = s_axi.wvalid & w_ok;
    assign s_axi.wready  = m_axi.wready & w_ok;

    assign ar_hs     = hs(m_axi.arvalid, m_axi.arready);
    assign r_last_hs = hs(m_axi.rvalid, s_axi.rready) & m_axi.rlast;
    assign aw_hs     = hs(m_axi.awvalid, m_axi.awready);
    assign b_hs      = hs(m_axi.bvalid, s_axi.bready);
    assign w_last_hs = hs(m_axi.wvalid, m_axi.wready) & s_axi.wlast;

    outstanding_ctr #(.CNT_W(CNT_W), .HAS_LIMIT(1'b1)) u_rd_ctr (
        .clk(uncoreclk), .rst_n(uncore_rstn), .inc(ar_hs), .dec(r_last_hs),
        .limit(cfg_max_rd), .count(stat_rd_outstanding), .ok(rd_ok), .underflow(rd_uf)
    );

    outstanding_ctr #(.CNT_W(CNT_W), .HAS_LIMIT(1'b1)) u_wr_ctr (
        .clk(uncoreclk), .rst_n(uncore_rstn), .inc(aw_hs), .dec(b_hs),
        .limit(cfg_max_wr), .count(stat_wr_outstanding), .ok(wr_ok), .underflow(wr_uf)
    );

    // W credit: one per accepted AW, returned when that burst's last beat goes out.
    outstanding_ctr #(.CNT_W(CNT_W), .HAS_LIMIT(1'b0)) u_w_cred (
        .clk(uncoreclk), .rst_n(uncore_rstn), .inc(aw_hs), .dec(w_last_hs),
        .limit('0), .count(w_cred_unused), .ok(w_ok), .underflow(wc_uf)
    );

    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            stat_rd_stall <= '0;
            stat_wr_stall <= '0;
            err_sticky    <= 1'b0;
        end else begin
            if (stat_clear) begin
                stat_rd_stall <= '0;
                stat_wr_stall <= '0;
            end else begin
                if (s_axi.arvalid && !rd_ok && !(&stat_rd_stall))
                    stat_rd_stall <= stat_rd_stall + STAT_W'(1);
                if (s_axi.awvalid && !wr_ok && !(&stat_wr_stall))
                    stat_wr_stall <= stat_wr_stall + STAT_W'(1);
            end
            if (rd_uf || wr_uf || wc_uf)
                err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_mem_outstanding_limiter.sv
// Bench for the outstanding limiter: directed scenarios then random traffic, all checked
// every cycle against a count-level model of outstanding bursts, W credit and stall stats.
module tb_axi_mem_outstanding_limiter;
    localparam int CNT_W  = 5;
    localparam int STAT_W = 4;
    localparam int SMAX   = (1 << STAT_W) - 1;

    logic clk;
    logic rst_n;
    logic [CNT_W-1:0]  cfg_max_rd, cfg_max_wr;
    logic [CNT_W-1:0]  stat_rd_outstanding, stat_wr_outstanding;
    logic [STAT_W-1:0] stat_rd_stall, stat_wr_stall;
    logic stat_clear;
    logic err_sticky;

    int tests_run = 0;
    int failed    = 0;
    int rd_m, wr_m, wc_m, rd_st, wr_st;
    bit err_m;

    axi_mem_outstanding_limiter_if s_if ();
    axi_mem_outstanding_limiter_if m_if ();

    axi_mem_outstanding_limiter #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .uncoreclk(clk), .uncore_rstn(rst_n), .s_axi(s_if.slave), .m_axi(m_if.master),
        .cfg_max_rd(cfg_max_rd), .cfg_max_wr(cfg_max_wr),
        .stat_rd_outstanding(stat_rd_outstanding), .stat_wr_outstanding(stat_wr_outstanding),
        .stat_rd_stall(stat_rd_stall), .stat_wr_stall(stat_wr_stall),
        .stat_clear(stat_clear), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rd_m = 0; wr_m = 0; wc_m = 0; rd_st = 0; wr_st = 0; err_m = 1'b0;
    endtask

    task automatic drive_idle();
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
        s_if.awlock = '0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awuser = '0;
        s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
        s_if.bready = 1'b0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
        s_if.arburst = '0; s_if.arlock = '0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0;
        s_if.aruser = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
        m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        m_if.rvalid = 1'b0;
        stat_clear = 1'b0;
    endtask

    task automatic rand_payload();
        s_if.awid = 1'($urandom); s_if.awaddr = $urandom; s_if.awlen = 8'($urandom);
        s_if.awsize = 3'($urandom); s_if.awburst = 2'($urandom); s_if.awlock = 1'($urandom);
        s_if.awcache = 4'($urandom); s_if.awprot = 3'($urandom); s_if.awqos = 4'($urandom);
        s_if.awuser = 1'($urandom); s_if.wdata = {$urandom, $urandom}; s_if.wstrb = 8'($urandom);
        s_if.arid = 1'($urandom); s_if.araddr = $urandom; s_if.arlen = 8'($urandom);
        s_if.arsize = 3'($urandom); s_if.arburst = 2'($urandom); s_if.arlock = 1'($urandom);
        s_if.arcache = 4'($urandom); s_if.arprot = 3'($urandom); s_if.arqos = 4'($urandom);
        s_if.aruser = 1'($urandom); m_if.bid = 1'($urandom); m_if.bresp = 2'($urandom);
        m_if.rid = 1'($urandom); m_if.rdata = {$urandom, $urandom}; m_if.rresp = 2'($urandom);
    endtask

    // One clock: inputs already driven; check combinational outputs at the falling edge,
    // advance the model by the handshakes the bus rules allow, then check registered stats.
    task automatic cycle();
        bit rd_ok, wr_ok, w_ok, ar_hs, r_hs, aw_hs, b_hs, w_hs;
        @(negedge clk);
        rd_ok = rd_m < int'(cfg_max_rd);
        wr_ok = wr_m < int'(cfg_max_wr);
        w_ok  = wc_m > 0;
        chk("m_arvalid", 64'(m_if.arvalid), 64'(s_if.arvalid & rd_ok));
        chk("s_arready", 64'(s_if.arready), 64'(m_if.arready & rd_ok));
        chk("m_awvalid", 64'(m_if.awvalid), 64'(s_if.awvalid & wr_ok));
        chk("s_awready", 64'(s_if.awready), 64'(m_if.awready & wr_ok));
        chk("m_wvalid", 64'(m_if.wvalid), 64'(s_if.wvalid & w_ok));
        chk("s_wready", 64'(s_if.wready), 64'(m_if.wready & w_ok));
        chk("b_pass", 64'({s_if.bvalid, m_if.bready}), 64'({m_if.bvalid, s_if.bready}));
        chk("r_pass", 64'({s_if.rvalid, m_if.rready}), 64'({m_if.rvalid, s_if.rready}));
        chk("aw_addr", 64'(m_if.awaddr), 64'(s_if.awaddr));
        chk("aw_fields", 64'({m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock,
                              m_if.awcache, m_if.awprot, m_if.awqos, m_if.awuser}),
                         64'({s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
                              s_if.awcache, s_if.awprot, s_if.awqos, s_if.awuser}));
        chk("ar_addr", 64'(m_if.araddr), 64'(s_if.araddr));
        chk("ar_fields", 64'({m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock,
                              m_if.arcache, m_if.arprot, m_if.arqos, m_if.aruser}),
                         64'({s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
                              s_if.arcache, s_if.arprot, s_if.arqos, s_if.aruser}));
        chk("w_data", m_if.wdata, s_if.wdata);
        chk("w_fields", 64'({m_if.wstrb, m_if.wlast}), 64'({s_if.wstrb, s_if.wlast}));
        chk("b_fields", 64'({s_if.bid, s_if.bresp}), 64'({m_if.bid, m_if.bresp}));
        chk("r_data", s_if.rdata, m_if.rdata);
        chk("r_fields", 64'({s_if.rid, s_if.rresp, s_if.rlast}), 64'({m_if.rid, m_if.rresp, m_if.rlast}));

        ar_hs = s_if.arvalid && rd_ok && m_if.arready;
        r_hs  = m_if.rvalid && s_if.rready && m_if.rlast;
        aw_hs = s_if.awvalid && wr_ok && m_if.awready;
        b_hs  = m_if.bvalid && s_if.bready;
        w_hs  = s_if.wvalid && w_ok && m_if.wready && s_if.wlast;
        if (stat_clear) begin
            rd_st = 0; wr_st = 0;
        end else begin
            if (s_if.arvalid && !rd_ok) rd_st = (rd_st == SMAX) ? SMAX : rd_st + 1;
            if (s_if.awvalid && !wr_ok) wr_st = (wr_st == SMAX) ? SMAX : wr_st + 1;
        end
        if (ar_hs && !r_hs) rd_m++;
        else if (r_hs && !ar_hs) begin if (rd_m == 0) err_m = 1'b1; else rd_m--; end
        if (aw_hs && !b_hs) wr_m++;
        else if (b_hs && !aw_hs) begin if (wr_m == 0) err_m = 1'b1; else wr_m--; end
        if (aw_hs && !w_hs) wc_m++;
        else if (w_hs && !aw_hs) wc_m--;

        @(posedge clk);
        #1;
        chk("rd_outstanding", 64'(stat_rd_outstanding), 64'(rd_m));
        chk("wr_outstanding", 64'(stat_wr_outstanding), 64'(wr_m));
        chk("rd_stall", 64'(stat_rd_stall), 64'(rd_st));
        chk("wr_stall", 64'(stat_wr_stall), 64'(wr_st));
        chk("err_sticky", 64'(err_sticky), 64'(err_m));
    endtask

    initial begin
        drive_idle();
        cfg_max_rd = '0; cfg_max_wr = '0; rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rd_cnt", 64'(stat_rd_outstanding), 64'd0);
        chk("reset_wr_cnt", 64'(stat_wr_outstanding), 64'd0);
        chk("reset_stalls", 64'({stat_rd_stall, stat_wr_stall}), 64'd0);
        chk("reset_err", 64'(err_sticky), 64'd0);

        // Both limits zero: nothing may issue.
        s_if.arvalid = 1'b1; s_if.awvalid = 1'b1; m_if.arready = 1'b1; m_if.awready = 1'b1;
        cycle();
        chk("zero_lim_ar", 64'(m_if.arvalid), 64'd0);
        drive_idle(); stat_clear = 1'b1; cycle(); stat_clear = 1'b0;

        // Read limit 2 with four single-beat ARs and delayed R.
        cfg_max_rd = 5'd2;
        s_if.arvalid = 1'b1; m_if.arready = 1'b1; s_if.rready = 1'b1;
        repeat (2) cycle();
        chk("rd_out_at_limit", 64'(stat_rd_outstanding), 64'd2);
        repeat (3) cycle();
        chk("rd_stall_3", 64'(stat_rd_stall), 64'd3);
        m_if.rvalid = 1'b1; m_if.rlast = 1'b1; cycle(); m_if.rvalid = 1'b0;
        chk("ar_after_rlast", 64'(m_if.arvalid), 64'd1);
        cycle();
        cycle();
        m_if.rvalid = 1'b1; cycle(); m_if.rvalid = 1'b0;
        cycle();
        s_if.arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rlast = 1'b0; cycle();
        m_if.rlast = 1'b1; repeat (2) cycle();
        chk("rd_drained", 64'(stat_rd_outstanding), 64'd0);
        drive_idle(); stat_clear = 1'b1; cycle(); stat_clear = 1'b0;

        // Same-cycle AR and R-last.
        s_if.rready = 1'b1; m_if.arready = 1'b1; s_if.arvalid = 1'b1; cycle();
        cfg_max_rd = 5'd1; m_if.rvalid = 1'b1; m_if.rlast = 1'b1; cycle();
        chk("collide_lim1", 64'(stat_rd_outstanding), 64'd0);
        cfg_max_rd = 5'd2; m_if.rvalid = 1'b0; cycle();
        m_if.rvalid = 1'b1; cycle();
        chk("collide_hold", 64'(stat_rd_outstanding), 64'd1);
        s_if.arvalid = 1'b0; cycle();
        drive_idle(); stat_clear = 1'b1; cycle(); stat_clear = 1'b0;

        // W presented before its AW.
        cfg_max_wr = 5'd4;
        s_if.wvalid = 1'b1; m_if.wready = 1'b1; rand_payload();
        repeat (3) cycle();
        chk("w_before_aw", 64'(m_if.wvalid), 64'd0);
        s_if.awvalid = 1'b1; s_if.awlen = 8'd3; m_if.awready = 1'b1; cycle();
        s_if.awvalid = 1'b0;
        repeat (3) cycle();
        s_if.wlast = 1'b1; cycle(); s_if.wlast = 1'b0;
        chk("w_cred_empty", 64'(m_if.wvalid), 64'd0);
        s_if.wvalid = 1'b0; m_if.bvalid = 1'b1; s_if.bready = 1'b1; cycle();
        drive_idle(); cycle();

        // Write limit zero: stall counting, clear and saturation.
        cfg_max_wr = 5'd0; s_if.awvalid = 1'b1; m_if.awready = 1'b1;
        repeat (10) cycle();
        chk("wr_stall_10", 64'(stat_wr_stall), 64'd10);
        stat_clear = 1'b1; cycle(); stat_clear = 1'b0;
        chk("wr_stall_clear", 64'(stat_wr_stall), 64'd0);
        repeat (20) cycle();
        chk("wr_stall_sat", 64'(stat_wr_stall), 64'(SMAX));
        drive_idle(); stat_clear = 1'b1; cycle(); stat_clear = 1'b0;

        // Spurious B with nothing outstanding.
        m_if.bvalid = 1'b1; s_if.bready = 1'b1; cycle(); drive_idle();
        chk("err_set", 64'(err_sticky), 64'd1);
        repeat (5) cycle();
        chk("err_hold", 64'(err_sticky), 64'd1);

        // Asynchronous reset with traffic in flight.
        cfg_max_rd = 5'd4; cfg_max_wr = 5'd4;
        s_if.arvalid = 1'b1; s_if.awvalid = 1'b1; m_if.arready = 1'b1; m_if.awready = 1'b1;
        repeat (2) cycle();
        s_if.awvalid = 1'b0; cycle(); s_if.arvalid = 1'b0;
        chk("pre_reset_rd", 64'(stat_rd_outstanding), 64'd3);
        chk("pre_reset_wr", 64'(stat_wr_outstanding), 64'd2);
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd", 64'(stat_rd_outstanding), 64'd0);
        chk("async_wr", 64'(stat_wr_outstanding), 64'd0);
        chk("async_stalls", 64'({stat_rd_stall, stat_wr_stall}), 64'd0);
        chk("async_err", 64'(err_sticky), 64'd0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        s_if.wvalid = 1'b1; m_if.wready = 1'b1; cycle();
        drive_idle();

        // Random traffic; responses only offered while something is outstanding.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                cfg_max_rd = 5'($urandom_range(0, 6));
                cfg_max_wr = 5'($urandom_range(0, 6));
            end
            rand_payload();
            s_if.arvalid = 1'($urandom); m_if.arready = 1'($urandom);
            s_if.awvalid = 1'($urandom); m_if.awready = 1'($urandom);
            s_if.wvalid  = 1'($urandom); m_if.wready  = 1'($urandom); s_if.wlast = 1'($urandom);
            m_if.rvalid  = (rd_m > 0) && ($urandom_range(0, 1) == 1);
            m_if.rlast   = 1'($urandom); s_if.rready = 1'($urandom);
            m_if.bvalid  = (wr_m > 0) && ($urandom_range(0, 1) == 1);
            s_if.bready  = 1'($urandom);
            stat_clear   = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
